mx_mac_seq_ctrl: RTL

Sequencer for one MX hybrid MAC processing element. Latches a tile configuration: precision mode, FP mode, shared exponent, reduction length K. Paces the A/B operand streams into the MAC with a joint valid/ready handshake, counts reduction steps and flags the first step so the accumulator feedback is zeroed. Captures the finished accumulator into an output register with its own valid/ready port. Sits between the stream/operand fetch logic and the MAC's A_valid/B_valid, prec_mode, FP_mode and shared_exp_added inputs.

---
 rtl/mx_ctrl_pkg.sv | 33 +++
 rtl/mx_out_slot.sv | 58 +++++
 rtl/mx_mac_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mx_ctrl_pkg.sv
// Shared types and helpers for the MX MAC sequencer: FSM states, precision
// encodings, the configuration bundle and the elements-per-step helper.
package mx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  localparam logic [1:0] PREC_8B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_2B = 2'd2;

  localparam int CFG_K_W = 16;

  typedef struct packed {
    logic [1:0]         prec;
    logic [1:0]         fp;
    logic [7:0]         shared_exp;
    logic [CFG_K_W-1:0] k_len;
  } cfg_t;

  // log2 of the number of elements the MAC consumes per step
  function automatic logic [2:0] eps_log2(input logic [1:0] prec);
    case (prec)
      PREC_8B: return 3'd2;
      PREC_4B: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mx_out_slot.sv
// One-entry result register with a valid/ready output port. A load and a
// consumption never land on the same edge, so load simply takes priority.
module mx_out_slot #(
  parameter int M_out_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   ready_i,
  input  logic [M_out_width-1:0] mant_i,
  input  logic [7:0]             exp_i,
  input  logic                   sign_i,
  output logic                   valid_o,
  output logic [M_out_width-1:0] mant_o,
  output logic [7:0]             exp_o,
  output logic                   sign_o
);

  logic                   valid_q, valid_d;
  logic [M_out_width-1:0] mant_q, mant_d;
  logic [7:0]             exp_q, exp_d;
  logic                   sign_q, sign_d;

  always_comb begin
    valid_d = valid_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    if (load_i) begin
      valid_d = 1'b1;
      mant_d  = mant_i;
      exp_d   = exp_i;
      sign_d  = sign_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
    end
  end

  assign valid_o = valid_q;
  assign mant_o  = mant_q;
  assign exp_o   = exp_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/mx_mac_seq_ctrl.sv
// Sequencer for one MX hybrid MAC PE: accepts a tile configuration, paces the
// joint A/B operand handshake for ceil(K/EPS) steps, then captures the result.
module mx_mac_seq_ctrl
  import mx_ctrl_pkg::*;
#(
  parameter int M_out_width = 16,
  parameter int K_W         = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [1:0]             cfg_prec_mode_i,
  input  logic [1:0]             cfg_fp_mode_i,
  input  logic [7:0]             cfg_shared_exp_i,
  input  logic [K_W-1:0]         cfg_k_len_i,
  output logic [1:0]             prec_mode_o,
  output logic [1:0]             fp_mode_o,
  output logic [7:0]             shared_exp_o,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic                   mac_a_valid_o,
  output logic                   mac_b_valid_o,
  output logic                   acc_first_o,
  input  logic [M_out_width-1:0] mac_mant_i,
  input  logic [7:0]             mac_exp_i,
  input  logic                   mac_sign_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [M_out_width-1:0] out_mant_o,
  output logic [7:0]             out_exp_o,
  output logic                   out_sign_o,
  output logic                   busy_o,
  output logic                   cfg_err_o
);

  state_e         state_q, state_d;
  logic [K_W-1:0] step_cnt_q, step_cnt_d;
  logic           first_q, first_d;
  logic [1:0]     prec_q, prec_d;
  logic [1:0]     fp_q, fp_d;
  logic [7:0]     exp_q, exp_d;

  cfg_t           cfg_in;
  logic           cfg_bad;
  logic [K_W:0]   k_ext, round_add, steps;
  logic [K_W-1:0] steps_m1;
  logic           run, last_step, gate, fire, capt, out_valid;

  always_comb begin
    cfg_in.prec       = cfg_prec_mode_i;
    cfg_in.fp         = cfg_fp_mode_i;
    cfg_in.shared_exp = cfg_shared_exp_i;
    cfg_in.k_len      = CFG_K_W'(cfg_k_len_i);
  end

  assign cfg_bad   = (cfg_in.prec == 2'd3) || (cfg_in.k_len == '0);
  // steps = ceil(K / EPS) by adding EPS-1 before the shift
  assign k_ext     = (K_W+1)'(cfg_in.k_len);
  assign round_add = (K_W+1)'((32'd1 << eps_log2(cfg_in.prec)) - 32'd1);
  assign steps     = (k_ext + round_add) >> eps_log2(cfg_in.prec);
  assign steps_m1  = K_W'(steps - (K_W+1)'(1));

  // Only the last step waits for the output slot; earlier steps of the next
  // tile overlap with an unconsumed previous result.
  assign run       = (state_q == ST_RUN);
  assign last_step = (step_cnt_q == '0);
  assign gate      = run & (!last_step | !out_valid | out_ready_i);
  assign fire      = a_valid_i & b_valid_i & gate;
  assign capt      = (state_q == ST_CAPT);

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    first_d     = first_q;
    prec_d      = prec_q;
    fp_d        = fp_q;
    exp_d       = exp_q;
    cfg_ready_o = 1'b0;
    cfg_err_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          if (cfg_bad) begin
            cfg_err_o = 1'b1;
          end else begin
            prec_d     = cfg_in.prec;
            fp_d       = cfg_in.fp;
            exp_d      = cfg_in.shared_exp;
            step_cnt_d = steps_m1;
            first_d    = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (fire) begin
          first_d    = 1'b0;
          step_cnt_d = step_cnt_q - K_W'(1);
          if (last_step) state_d = ST_CAPT;
        end
      end
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      first_q    <= 1'b0;
      prec_q     <= '0;
      fp_q       <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      first_q    <= first_d;
      prec_q     <= prec_d;
      fp_q       <= fp_d;
      exp_q      <= exp_d;
    end
  end

  mx_out_slot #(.M_out_width(M_out_width)) u_out_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (capt),
    .ready_i (out_ready_i),
    .mant_i  (mac_mant_i),
    .exp_i   (mac_exp_i),
    .sign_i  (mac_sign_i),
    .valid_o (out_valid),
    .mant_o  (out_mant_o),
    .exp_o   (out_exp_o),
    .sign_o  (out_sign_o)
  );

  // Ready depends on the partner's valid only, never on its own
  assign a_ready_o     = b_valid_i & gate;
  assign b_ready_o     = a_valid_i & gate;
  assign mac_a_valid_o = fire;
  assign mac_b_valid_o = fire;
  assign acc_first_o   = fire & first_q;
  assign out_valid_o   = out_valid;
  assign prec_mode_o   = prec_q;
  assign fp_mode_o     = fp_q;
  assign shared_exp_o  = exp_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
